// File: rtl/sump_cmd_transmitter.sv
// rtl/sump_cmd_transmitter.sv - SUMP command serializer onto an 8N1 UART tx line.
// Optional SUMP_CMD_RESET_EN adds send_reset, which queues five 0x00 bytes as one sequence.
module sump_cmd_transmitter #(
    parameter int FREQ = 100000000,
    parameter int RATE = 115200
) (
    input  logic        clock,
    input  logic        extReset_n,
    input  logic        cmd_valid,
    input  logic [39:0] cmd,
    output logic        cmd_ready,
    output logic        tx,
    output logic        busy,
    output logic        done
`ifdef SUMP_CMD_RESET_EN
    ,
    input  logic        send_reset
`endif
);

    localparam int DIV = FREQ / RATE;
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [2:0]    bytes_q, bytes_d;
    logic [39:0]   shift_q, shift_d;
    logic          tx_q, tx_d;

    logic          start_req;
    logic [39:0]   start_shift;
    logic [2:0]    start_bytes;
    logic          bit_end;
    logic [2:0]    nxt_bit;

    assign cmd_ready = (state_q == IDLE);
    assign busy      = ~cmd_ready;
    assign tx        = tx_q;
    assign bit_end   = (cnt_q == CNT_LAST);
    assign nxt_bit   = bit_q + 3'd1;
    assign done      = (state_q == STOP) && bit_end && (bytes_q == 3'd1);

    // A reset sequence is just five zero bytes: a cleared shift register yields 0x00 each time.
    always_comb begin
`ifdef SUMP_CMD_RESET_EN
        start_req   = send_reset | cmd_valid;
        start_shift = send_reset ? 40'd0 : cmd;
        start_bytes = (send_reset | cmd[7]) ? 3'd5 : 3'd1;
`else
        start_req   = cmd_valid;
        start_shift = cmd;
        start_bytes = cmd[7] ? 3'd5 : 3'd1;
`endif
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = bit_end ? '0 : cnt_q + CW'(1);
        bit_d   = bit_q;
        bytes_d = bytes_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (start_req) begin
                    state_d = START;
                    tx_d    = 1'b0;
                    shift_d = start_shift;
                    bytes_d = start_bytes;
                    bit_d   = 3'd0;
                end
            end
            START: begin
                if (bit_end) begin
                    state_d = DATA;
                    tx_d    = shift_q[0];
                    bit_d   = 3'd0;
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                        tx_d    = 1'b1;
                    end else begin
                        bit_d = nxt_bit;
                        tx_d  = shift_q[nxt_bit];
                    end
                end
            end
            STOP: begin
                if (bit_end) begin
                    if (bytes_q > 3'd1) begin
                        state_d = START;
                        tx_d    = 1'b0;
                        shift_d = shift_q >> 8;
                        bytes_d = bytes_q - 3'd1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge extReset_n) begin
        if (!extReset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= 3'd0;
            bytes_q <= 3'd0;
            shift_q <= 40'd0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            bytes_q <= bytes_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
        end
    end

endmodule

// File: tb/tb_sump_cmd_transmitter.sv
// tb/tb_sump_cmd_transmitter.sv - randomized self-checking bench for sump_cmd_transmitter.
module tb_sump_cmd_transmitter;

    localparam int DIV = 10;
    localparam int FB  = 10 * DIV;
    localparam int MAXN = 1200;

    logic        clock = 1'b0;
    logic        extReset_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic [39:0] cmd = 40'd0;
    logic        send_reset = 1'b0;
    logic        cmd_ready, tx, busy, done;

    int checks = 0;
    int fails  = 0;

    logic tx_a   [0:MAXN-1];
    logic done_a [0:MAXN-1];
    logic busy_a [0:MAXN-1];
    logic rdy_a  [0:MAXN-1];
    logic exp_tx   [0:MAXN-1];
    logic exp_done [0:MAXN-1];
    logic exp_busy [0:MAXN-1];

    sump_cmd_transmitter #(.FREQ(100000000), .RATE(10000000)) dut (
        .clock      (clock),
        .extReset_n (extReset_n),
        .cmd_valid  (cmd_valid),
        .cmd        (cmd),
        .cmd_ready  (cmd_ready),
        .tx         (tx),
        .busy       (busy),
        .done       (done)
`ifdef SUMP_CMD_RESET_EN
        ,
        .send_reset (send_reset)
`endif
    );

    always #5 clock = ~clock;

    // Reference: line idle unless a frame list says otherwise.
    task automatic model_clear(input int n);
        for (int k = 0; k < n; k++) begin
            exp_tx[k] = 1'b1; exp_done[k] = 1'b0; exp_busy[k] = 1'b0;
        end
    endtask

    // Each byte is start(0), 8 data bits LSB first, stop(1); DIV clocks per bit.
    task automatic model_frame(input int off, input logic [39:0] c, input int nb);
        logic [7:0] by;
        logic       bv;
        for (int b = 0; b < nb; b++) begin
            by = c[8*b +: 8];
            for (int p = 0; p < 10; p++) begin
                bv = (p == 0) ? 1'b0 : (p == 9) ? 1'b1 : by[p-1];
                for (int d = 0; d < DIV; d++) begin
                    exp_tx[off + (b*10 + p)*DIV + d]   = bv;
                    exp_busy[off + (b*10 + p)*DIV + d] = 1'b1;
                end
            end
        end
        exp_done[off + nb*FB - 1] = 1'b1;
    endtask

    task automatic capture(input int n, input int drop_at);
        for (int k = 0; k < n; k++) begin
            tx_a[k] = tx; done_a[k] = done; busy_a[k] = busy; rdy_a[k] = cmd_ready;
            if (k == drop_at) cmd_valid = 1'b0;
            @(negedge clock);
        end
    endtask

    task automatic wait_idle();
        int t = 0;
        while (!cmd_ready && t < 2000) begin
            @(negedge clock);
            t++;
        end
        checks++;
        if (cmd_ready !== 1'b1) begin
            fails++;
            $display("FAIL wait_idle: cmd_ready got %b want 1 within 2000 cycles", cmd_ready);
        end
    endtask

    // Leaves the bench at the negedge just after the accepting rising edge.
    task automatic issue(input logic [39:0] c);
        wait_idle();
        cmd = c;
        cmd_valid = 1'b1;
        @(negedge clock);
    endtask

    task automatic test_reset();
        cmd_valid = 1'b1;
        cmd = 40'h00_0000_0001;
        repeat (3) @(negedge clock);
        checks++;
        if ({tx, busy, done, cmd_ready} !== 4'b1001) begin
            fails++;
            $display("FAIL reset_state: tx/busy/done/ready got %b%b%b%b want 1001", tx, busy, done, cmd_ready);
        end
        cmd_valid = 1'b0;
        extReset_n = 1'b1;
        repeat (2) @(negedge clock);
        checks++;
        if ({tx, busy, cmd_ready} !== 3'b101) begin
            fails++;
            $display("FAIL post_reset_idle: tx/busy/ready got %b%b%b want 101", tx, busy, cmd_ready);
        end
    endtask

    task automatic test_short();
        logic [39:0] c = {$urandom(), 8'h01};
        issue(c);
        capture(FB + 5, 0);
        model_clear(FB + 5);
        model_frame(0, c, 1);
        for (int k = 0; k < FB + 5; k++) begin
            checks++;
            if ({tx_a[k], done_a[k], busy_a[k], rdy_a[k]} !== {exp_tx[k], exp_done[k], exp_busy[k], ~exp_busy[k]}) begin
                fails++;
                $display("FAIL short_frame cyc %0d: tx/done/busy/ready got %b%b%b%b want %b%b%b%b", k,
                         tx_a[k], done_a[k], busy_a[k], rdy_a[k], exp_tx[k], exp_done[k], exp_busy[k], ~exp_busy[k]);
                break;
            end
        end
    endtask

    task automatic test_long();
        logic [39:0] c = {32'h12345678, 8'h80};
        issue(c);
        capture(5*FB + 5, 0);
        model_clear(5*FB + 5);
        model_frame(0, c, 5);
        for (int k = 0; k < 5*FB + 5; k++) begin
            checks++;
            if ({tx_a[k], done_a[k], busy_a[k], rdy_a[k]} !== {exp_tx[k], exp_done[k], exp_busy[k], ~exp_busy[k]}) begin
                fails++;
                $display("FAIL long_frame cyc %0d: tx/done/busy/ready got %b%b%b%b want %b%b%b%b", k,
                         tx_a[k], done_a[k], busy_a[k], rdy_a[k], exp_tx[k], exp_done[k], exp_busy[k], ~exp_busy[k]);
                break;
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [39:0] c1 = {$urandom(), 1'b0, 7'($urandom())};
        int n = 2*FB + 6;
        issue(c1);
        cmd = 40'h00_0000_0002;
        capture(n, FB + 1);
        model_clear(n);
        model_frame(0, c1, 1);
        model_frame(FB + 1, 40'h00_0000_0002, 1);
        for (int k = 0; k < n; k++) begin
            checks++;
            if ({tx_a[k], done_a[k], busy_a[k], rdy_a[k]} !== {exp_tx[k], exp_done[k], exp_busy[k], ~exp_busy[k]}) begin
                fails++;
                $display("FAIL back_to_back cyc %0d: tx/done/busy/ready got %b%b%b%b want %b%b%b%b", k,
                         tx_a[k], done_a[k], busy_a[k], rdy_a[k], exp_tx[k], exp_done[k], exp_busy[k], ~exp_busy[k]);
                break;
            end
        end
    endtask

    task automatic test_cmd_change();
        logic [39:0] c = {$urandom(), 1'b1, 7'($urandom())};
        issue(c);
        cmd = ~c;
        capture(5*FB + 5, 0);
        model_clear(5*FB + 5);
        model_frame(0, c, 5);
        for (int k = 0; k < 5*FB + 5; k++) begin
            checks++;
            if ({tx_a[k], done_a[k], busy_a[k], rdy_a[k]} !== {exp_tx[k], exp_done[k], exp_busy[k], ~exp_busy[k]}) begin
                fails++;
                $display("FAIL cmd_change cyc %0d: tx/done/busy/ready got %b%b%b%b want %b%b%b%b", k,
                         tx_a[k], done_a[k], busy_a[k], rdy_a[k], exp_tx[k], exp_done[k], exp_busy[k], ~exp_busy[k]);
                break;
            end
        end
    endtask

    task automatic test_abort();
        issue({32'h0F0F_F0F0, 8'hA5});
        capture(35, 0);
        extReset_n = 1'b0;
        #1;
        checks++;
        if ({tx, busy, done, cmd_ready} !== 4'b1001) begin
            fails++;
            $display("FAIL abort_async: tx/busy/done/ready got %b%b%b%b want 1001", tx, busy, done, cmd_ready);
        end
        @(negedge clock);
        extReset_n = 1'b1;
        capture(FB + 5, -1);
        model_clear(FB + 5);
        for (int k = 0; k < FB + 5; k++) begin
            checks++;
            if ({tx_a[k], done_a[k], busy_a[k], rdy_a[k]} !== {exp_tx[k], exp_done[k], exp_busy[k], ~exp_busy[k]}) begin
                fails++;
                $display("FAIL abort_idle cyc %0d: tx/done/busy/ready got %b%b%b%b want 1001", k,
                         tx_a[k], done_a[k], busy_a[k], rdy_a[k]);
                break;
            end
        end
    endtask

    task automatic test_random();
        logic [39:0] c;
        int nb;
        for (int i = 0; i < 6; i++) begin
            c  = {$urandom(), 8'($urandom())};
            nb = c[7] ? 5 : 1;
            issue(c);
            capture(nb*FB + 3, 0);
            model_clear(nb*FB + 3);
            model_frame(0, c, nb);
            for (int k = 0; k < nb*FB + 3; k++) begin
                checks++;
                if ({tx_a[k], done_a[k], busy_a[k], rdy_a[k]} !== {exp_tx[k], exp_done[k], exp_busy[k], ~exp_busy[k]}) begin
                    fails++;
                    $display("FAIL random_cmd %h cyc %0d: tx/done/busy/ready got %b%b%b%b want %b%b%b%b", c, k,
                             tx_a[k], done_a[k], busy_a[k], rdy_a[k], exp_tx[k], exp_done[k], exp_busy[k], ~exp_busy[k]);
                    break;
                end
            end
        end
    endtask

`ifdef SUMP_CMD_RESET_EN
    task automatic test_send_reset();
        wait_idle();
        cmd = {$urandom(), 8'h81};
        cmd_valid = 1'b1;
        send_reset = 1'b1;
        @(negedge clock);
        send_reset = 1'b0;
        capture(5*FB + 5, 0);
        model_clear(5*FB + 5);
        model_frame(0, 40'd0, 5);
        for (int k = 0; k < 5*FB + 5; k++) begin
            checks++;
            if ({tx_a[k], done_a[k], busy_a[k], rdy_a[k]} !== {exp_tx[k], exp_done[k], exp_busy[k], ~exp_busy[k]}) begin
                fails++;
                $display("FAIL send_reset cyc %0d: tx/done/busy/ready got %b%b%b%b want %b%b%b%b", k,
                         tx_a[k], done_a[k], busy_a[k], rdy_a[k], exp_tx[k], exp_done[k], exp_busy[k], ~exp_busy[k]);
                break;
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_short();
        test_long();
        test_back_to_back();
        test_cmd_change();
        test_abort();
        test_random();
`ifdef SUMP_CMD_RESET_EN
        test_send_reset();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
